// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-N stream demultiplexer with unicast/broadcast and a saturating drop counter
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   producer handshake; in_ready never depends on in_valid
//   in_data, in_sel     input word and target channel index
//   in_bcast            copy the word to every channel, in_sel ignored
//   out_valid/out_ready per-channel consumer handshake
//   out_data            channel k in bits [k*DW +: DW]
//   drop_cnt            words consumed with an out-of-range in_sel
module stream_demux_n #(
   parameter int N_CH = 4,
   parameter int DW = 8,
   parameter int CNT_W = 8,
   localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_data,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic              in_bcast,
   output logic [N_CH-1:0]   out_valid,
   input  logic [N_CH-1:0]   out_ready,
   output logic [N_CH*DW-1:0] out_data,
   output logic [CNT_W-1:0]  drop_cnt
);
   logic [N_CH-1:0] free, hit, load;
   logic sel_ok, acc;
   always_comb begin
      hit = '0;
      for (int k = 0; k < N_CH; k++) hit[k] = 32'(in_sel) == k;
   end
   assign sel_ok = 32'(in_sel) < N_CH;
   // a channel draining this cycle can take a new word at the same edge
   assign free = ~out_valid | out_ready;
   // out-of-range selects are always accepted so they can be dropped
   assign in_ready = in_bcast ? &free : sel_ok ? |(free & hit) : 1'b1;
   assign acc = in_valid & in_ready;
   assign load = acc ? (in_bcast ? '1 : hit) : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= '0;
         out_data <= '0;
      end else
         for (int k = 0; k < N_CH; k++)
            if (load[k]) begin
               out_valid[k] <= 1'b1;
               out_data[k*DW +: DW] <= in_data;
            end else if (out_ready[k])
               out_valid[k] <= 1'b0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) drop_cnt <= '0;
      else if (acc && !in_bcast && !sel_ok && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n: directed and random checks of stream_demux_n against a queue-based reference
module tb_stream_demux_n;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   logic in_valid = 0, in_bcast = 0, in_ready;
   logic [7:0] in_data = 0;
   logic [1:0] in_sel = 0;
   logic [3:0] out_valid, out_ready = 0;
   logic [31:0] out_data;
   logic [3:0] drop_cnt;
   logic v3 = 0, b3 = 0, rdy3;
   logic [1:0] s3 = 0;
   logic [7:0] d3 = 0;
   logic [2:0] ov3, or3 = 0;
   logic [23:0] od3;
   logic [3:0] dc3;
   int n_chk = 0, n_fail = 0;
   logic [3:0] mv = 0;
   logic [7:0] md[4] = '{default: 0};
   logic [7:0] q[4][$];

   stream_demux_n #(.N_CH(4), .DW(8), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .drop_cnt(drop_cnt));
   stream_demux_n #(.N_CH(3), .DW(8), .CNT_W(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
      .in_sel(s3), .in_bcast(b3), .out_valid(ov3), .out_ready(or3),
      .out_data(od3), .drop_cnt(dc3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mv = 0;
      for (int k = 0; k < 4; k++) begin
         md[k] = 0;
         q[k].delete();
      end
   endtask

   // one clock of dut4 from posedge+1 to the next posedge+1, checked against the reference
   task automatic cyc();
      logic [3:0] fr, ld, r;
      logic [7:0] d;
      logic rdy;
      #1;
      fr = ~mv | out_ready;
      rdy = in_bcast ? &fr : fr[in_sel];
      chk("in_ready", in_ready, rdy);
      ld = !(in_valid && rdy) ? 4'b0 : in_bcast ? 4'hF : 4'b1 << in_sel;
      d = in_data;
      r = out_ready;
      for (int k = 0; k < 4; k++)
         if (out_valid[k] && out_ready[k]) begin
            if (q[k].size() == 0) chk("unexpected_word", 1, 0);
            else chk($sformatf("order_ch%0d", k), out_data[k*8 +: 8], q[k].pop_front());
         end
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
         if (ld[k]) begin
            mv[k] = 1;
            md[k] = d;
            q[k].push_back(d);
         end else if (r[k]) mv[k] = 0;
      chk("out_valid", out_valid, mv);
      for (int k = 0; k < 4; k++) chk($sformatf("out_data_ch%0d", k), out_data[k*8 +: 8], md[k]);
      chk("drop_cnt4", drop_cnt, 0);
   endtask

   task automatic send(input logic [1:0] s, input logic [7:0] d, input logic b);
      in_valid = 1;
      in_sel = s;
      in_data = d;
      in_bcast = b;
      cyc();
   endtask

   initial begin
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_drop_cnt3", dc3, 0);
      #10 rst_n = 1;
      @(posedge clk);
      #1;
      // unicast sweep
      out_ready = 4'hF;
      for (int s = 0; s < 4; s++) begin
         send(2'(s), 8'hA5, 0);
         chk("sweep_valid", out_valid, 32'(4'b1 << s));
         chk("sweep_data", out_data[s*8 +: 8], 8'hA5);
      end
      in_valid = 0;
      cyc();
      // backpressure on ch2 while ch0 keeps flowing
      out_ready = 4'b1011;
      send(2, 8'h11, 0);
      in_data = 8'h22;
      cyc();
      chk("bp_blocked", in_ready, 0);
      chk("bp_hold", out_data[23:16], 8'h11);
      for (int i = 0; i < 3; i++) begin
         send(0, 8'(8'h50 + i), 0);
         chk("bp_ch0_flow", out_valid[0], 1);
      end
      out_ready = 4'hF;
      send(2, 8'h22, 0);
      chk("bp_reload", out_data[23:16], 8'h22);
      in_valid = 0;
      cyc();
      // broadcast is all-or-nothing
      out_ready = 4'b1101;
      send(1, 8'h77, 0);
      send(0, 8'h3C, 1);
      chk("bc_blocked", out_valid, 4'b0010);
      chk("bc_ch1_hold", out_data[15:8], 8'h77);
      out_ready = 4'hF;
      send(0, 8'h3C, 1);
      chk("bc_valid", out_valid, 4'hF);
      chk("bc_data", out_data, 32'h3C3C3C3C);
      in_valid = 0;
      in_bcast = 0;
      cyc();
      // drops on a 3-channel instance
      v3 = 1;
      s3 = 2'b11;
      d3 = 8'h99;
      for (int i = 0; i < 20; i++) begin
         #1 chk("drop_ready3", rdy3, 1);
         cyc();
         chk("drop_valid3", ov3, 0);
         chk("drop_cnt3", dc3, (i + 1 > 15) ? 15 : i + 1);
      end
      v3 = 0;
      // asynchronous reset with words held on ch0 and ch3
      out_ready = 0;
      send(0, 8'hC0, 0);
      send(3, 8'hC3, 0);
      in_valid = 0;
      #3 rst_n = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_drop3", dc3, 0);
      model_clear();
      @(posedge clk);
      #3 rst_n = 1;
      @(posedge clk);
      #1;
      cyc();
      chk("post_rst_idle", out_valid, 0);
      // random traffic
      for (int i = 0; i < 2000; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_sel = 2'($urandom_range(0, 3));
         in_bcast = ($urandom_range(0, 7) == 0);
         in_data = 8'($urandom);
         out_ready = 4'($urandom);
         cyc();
      end
      in_valid = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
